counter_period_capture: RTL and testbench

//  Receive-side companion of the programmable match counter.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_period_capture.sv | 164 ++++++++++++++++
 tb/tb_counter_period_capture.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for counter_period_capture.
//   cpc_state_t : measurement FSM state (IDLE, MEASURE)
//   cpc_width() : counter/period width for a given MAX, never below one bit
package counter_pkg;

  typedef enum logic {IDLE, MEASURE} cpc_state_t;

  localparam int unsigned CPC_MIN_WIDTH = 1;

  // $clog2 returns 0 for MAX=1, which would give zero-width ports.
  function automatic int unsigned cpc_width(input int unsigned max_val);
    return (max_val < 2) ? CPC_MIN_WIDTH : $clog2(max_val);
  endfunction

endpackage

// File: rtl/counter_period_capture.sv
// Measures the interval between single-cycle tick events and reports it as a match value
// (interval - 1), so a match counter loaded with M reads back as M. Asserts o_locked after
// LOCK_CNT consecutive identical periods.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_clear      synchronous clear: back to IDLE, clears overflow, streak and lock
//   i_enable     measurement enable; low forces IDLE on the next cycle
//   i_tick       event strobe, sampled every cycle
//   o_period     last captured period (interval - 1)
//   o_valid      one-cycle pulse when o_period updates
//   o_locked     LOCK_CNT consecutive equal periods seen
//   o_overflow   sticky: no tick within MAX cycles while measuring
//   o_period_min / o_period_max  (only with COUNTER_PERIOD_CAPTURE_MINMAX_EN defined)
//                running extremes of captured periods; reset/clear -> min='1, max=0
module counter_period_capture
  import counter_pkg::*;
#(
  parameter int unsigned MAX      = 32,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_enable,
  input  logic                        i_tick,
  output logic [cpc_width(MAX)-1:0]   o_period,
  output logic                        o_valid,
  output logic                        o_locked,
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
  output logic [cpc_width(MAX)-1:0]   o_period_min,
  output logic [cpc_width(MAX)-1:0]   o_period_max,
`endif
  output logic                        o_overflow
);

  localparam int unsigned W  = cpc_width(MAX);
  localparam int unsigned SW = $clog2(LOCK_CNT + 1);

  cpc_state_t      state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [SW-1:0]   new_streak;
  logic [W-1:0]    period_q, period_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;
  logic            overflow_q, overflow_d;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
  logic [W-1:0]    min_q, min_d;
  logic [W-1:0]    max_q, max_d;
`endif

  // Streak value a capture in this cycle would produce. A zero streak means this is the
  // first capture since IDLE, so there is no previous period to compare against.
  always_comb begin
    new_streak = SW'(1);
    if (streak_q != '0 && cnt_q == period_q) begin
      new_streak = (streak_q < SW'(LOCK_CNT)) ? streak_q + SW'(1) : streak_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    overflow_d = overflow_q;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
`endif

    if (i_clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      streak_d   = '0;
      locked_d   = 1'b0;
      overflow_d = 1'b0;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
      min_d      = '1;
      max_d      = '0;
`endif
    end else if (!i_enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      streak_d = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // First tick only opens the window; there is nothing to capture yet.
          if (i_tick) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE: begin
          if (i_tick) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = '0;
            streak_d = new_streak;
            locked_d = (new_streak >= SW'(LOCK_CNT));
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
            if (cnt_q < min_q) min_d = cnt_q;
            if (cnt_q > max_q) max_d = cnt_q;
`endif
          end else if (cnt_q == W'(MAX - 1)) begin
            // Checked before incrementing so the counter never wraps.
            state_d    = IDLE;
            cnt_d      = '0;
            overflow_d = 1'b1;
            streak_d   = '0;
            locked_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
      min_q      <= '1;
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      overflow_q <= overflow_d;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

  assign o_period   = period_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_overflow = overflow_q;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
  assign o_period_min = min_q;
  assign o_period_max = max_q;
`endif

endmodule

// File: tb/tb_counter_period_capture.sv
// Self-checking bench for counter_period_capture: directed scenarios followed by randomized
// tick trains, all compared every cycle against a timestamp-based reference model.
module tb_counter_period_capture;

  localparam int unsigned MAX      = 32;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned W        = $clog2(MAX);

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_clear;
  logic         i_enable;
  logic         i_tick;
  logic [W-1:0] o_period;
  logic         o_valid;
  logic         o_locked;
  logic         o_overflow;
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
  logic [W-1:0] o_period_min;
  logic [W-1:0] o_period_max;
`endif

  counter_period_capture #(
    .MAX      (MAX),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_enable     (i_enable),
    .i_tick       (i_tick),
    .o_period     (o_period),
    .o_valid      (o_valid),
    .o_locked     (o_locked),
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
    .o_period_min (o_period_min),
    .o_period_max (o_period_max),
`endif
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: remembers when the window opened / last tick happened and derives the
  // period from elapsed time; the lock is a run length of equal periods.
  bit m_measuring;
  int m_last;
  int m_period;
  bit m_valid;
  bit m_locked;
  bit m_overflow;
  int m_run;
  int m_min;
  int m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_measuring = 0;
    m_last      = 0;
    m_period    = 0;
    m_valid     = 0;
    m_locked    = 0;
    m_overflow  = 0;
    m_run       = 0;
    m_min       = MAX - 1;
    m_max       = 0;
  endtask

  task automatic m_clock(input bit clr, input bit en, input bit tk);
    int elapsed;
    elapsed = cyc - m_last;
    m_valid = 0;
    if (clr) begin
      m_measuring = 0;
      m_overflow  = 0;
      m_locked    = 0;
      m_run       = 0;
      m_min       = MAX - 1;
      m_max       = 0;
    end else if (!en) begin
      m_measuring = 0;
      m_locked    = 0;
      m_run       = 0;
    end else if (!m_measuring) begin
      if (tk) begin
        m_measuring = 1;
        m_last      = cyc;
      end
    end else if (tk) begin
      m_run    = (m_run > 0 && (elapsed - 1) == m_period) ? m_run + 1 : 1;
      m_period = elapsed - 1;
      m_valid  = 1;
      m_locked = (m_run >= LOCK_CNT);
      m_last   = cyc;
      if (m_period < m_min) m_min = m_period;
      if (m_period > m_max) m_max = m_period;
    end else if (elapsed == MAX) begin
      m_measuring = 0;
      m_overflow  = 1;
      m_locked    = 0;
      m_run       = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".period"},   32'(o_period),   32'(m_period));
    check({tag, ".valid"},    32'(o_valid),    32'(m_valid));
    check({tag, ".locked"},   32'(o_locked),   32'(m_locked));
    check({tag, ".overflow"}, 32'(o_overflow), 32'(m_overflow));
`ifdef COUNTER_PERIOD_CAPTURE_MINMAX_EN
    check({tag, ".min"},      32'(o_period_min), 32'(m_min));
    check({tag, ".max"},      32'(o_period_max), 32'(m_max));
`endif
  endtask

  task automatic step(input bit clr, input bit en, input bit tk);
    i_clear  = clr;
    i_enable = en;
    i_tick   = tk;
    @(posedge i_clk);
    cyc++;
    m_clock(clr, en, tk);
    #1;
    check_all("cyc");
  endtask

  // Tick n cycles after the previous tick.
  task automatic tick_after(input int n);
    repeat (n - 1) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    i_rst    = 1'b1;
    i_clear  = 1'b0;
    i_enable = 1'b0;
    i_tick   = 1'b0;
    m_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("reset.period",   32'(o_period),   32'd0);
    check("reset.valid",    32'(o_valid),    32'd0);
    check("reset.locked",   32'(o_locked),   32'd0);
    check("reset.overflow", 32'(o_overflow), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Ticks every 8 cycles: period 7, lock on the 4th capture.
    step(1'b0, 1'b1, 1'b1);
    check("t1.first_no_valid", 32'(o_valid), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick_after(8);
      check("t1.period", 32'(o_period), 32'd7);
      check("t1.valid",  32'(o_valid),  32'd1);
      check("t1.locked", 32'(o_locked), (i >= 4) ? 32'd1 : 32'd0);
    end

    // Tick held high: period 0.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1);
    check("t2.period", 32'(o_period), 32'd0);

    // Lock at 7, then interval 5 breaks the lock, then relock.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (5) tick_after(8);
    check("t3.locked7", 32'(o_locked), 32'd1);
    tick_after(5);
    check("t3.period4", 32'(o_period), 32'd4);
    check("t3.unlock",  32'(o_locked), 32'd0);
    repeat (3) tick_after(5);
    check("t3.relock",  32'(o_locked), 32'd1);

    // Overflow: one tick then silence.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    check("t4.overflow", 32'(o_overflow), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("t4.cleared",  32'(o_overflow), 32'd0);

    // Interval of exactly MAX is a valid capture.
    step(1'b0, 1'b1, 1'b1);
    tick_after(MAX);
    check("edge.max_period", 32'(o_period),   32'(MAX - 1));
    check("edge.no_ovf",     32'(o_overflow), 32'd0);

    // Clear coincident with tick while locked.
    repeat (4) tick_after(8);
    check("t5.locked", 32'(o_locked), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("t5.no_valid", 32'(o_valid),  32'd0);
    check("t5.unlock",   32'(o_locked), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("t5.restart_no_valid", 32'(o_valid), 32'd0);
    tick_after(8);
    check("t5.capture", 32'(o_valid), 32'd1);

    // Async reset mid-measurement.
    repeat (10) step(1'b0, 1'b1, 1'b0);
    i_tick = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    m_reset();
    check("t6.period",   32'(o_period),   32'd0);
    check("t6.valid",    32'(o_valid),    32'd0);
    check("t6.locked",   32'(o_locked),   32'd0);
    check("t6.overflow", 32'(o_overflow), 32'd0);
    check_all("t6");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Randomized tick trains with occasional clear, disable and stray ticks.
    for (int b = 0; b < 80; b++) begin
      int p;
      int reps;
      p    = $urandom_range(0, MAX + 3);
      reps = $urandom_range(1, 7);
      for (int r = 0; r < reps; r++) begin
        for (int k = 0; k < p; k++) begin
          step(($urandom_range(0, 199) == 0), ($urandom_range(0, 149) != 0),
               ($urandom_range(0, 99) == 0));
        end
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) != 0), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
